// File: rtl/move_sequencer.sv
// Move descriptor FIFO plus tick sequencer that feeds the step-timing datapath.
// Runs one move at a time: a load strobe, then one tick per divided clock period.
module move_sequencer #(
    parameter int MOVE_BUFFER_BITS = 2,
    parameter int W                = 64,
    parameter int DIV_W            = 24
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      move_valid,
    output logic                      move_ready,
    input  logic [W-1:0]              move_duration,
    input  logic [W-1:0]              move_increment,
    input  logic [W-1:0]              move_incrementincrement,
    input  logic                      move_dir,
    input  logic [DIV_W-1:0]          clock_divisor,
    input  logic                      abort,
    output logic                      load,
    output logic                      tick,
    output logic                      move_done,
    output logic [W-1:0]              cur_increment,
    output logic [W-1:0]              cur_incrementincrement,
    output logic                      cur_dir,
    output logic                      active,
    output logic [MOVE_BUFFER_BITS:0] queue_count
);

    localparam int DEPTH = 1 << MOVE_BUFFER_BITS;

    localparam logic [MOVE_BUFFER_BITS:0]   CNT_ZERO = {(MOVE_BUFFER_BITS+1){1'b0}};
    localparam logic [MOVE_BUFFER_BITS:0]   CNT_ONE  = (MOVE_BUFFER_BITS+1)'(1'b1);
    localparam logic [MOVE_BUFFER_BITS:0]   CNT_FULL = {1'b1, {MOVE_BUFFER_BITS{1'b0}}};
    localparam logic [MOVE_BUFFER_BITS-1:0] PTR_ZERO = {MOVE_BUFFER_BITS{1'b0}};
    localparam logic [MOVE_BUFFER_BITS-1:0] PTR_ONE  = MOVE_BUFFER_BITS'(1'b1);
    localparam logic [W-1:0]                VAL_ZERO = {W{1'b0}};
    localparam logic [W-1:0]                VAL_ONE  = W'(1'b1);
    localparam logic [DIV_W-1:0]            DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]            DIV_ONE  = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0]            DIV_TWO  = DIV_W'(2'd2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic [W-1:0]                dur_mem_r    [DEPTH];
    logic [W-1:0]                inc_mem_r    [DEPTH];
    logic [W-1:0]                incinc_mem_r [DEPTH];
    logic                        dir_mem_r    [DEPTH];
    logic [MOVE_BUFFER_BITS-1:0] wr_ptr_r;
    logic [MOVE_BUFFER_BITS-1:0] rd_ptr_r;
    logic [MOVE_BUFFER_BITS:0]   count_r;

    state_t                      state_r;
    logic [W-1:0]                rem_r;
    logic [DIV_W-1:0]            div_r;
    logic [DIV_W-1:0]            d_r;
    logic                        chain_r;
    logic                        load_r;
    logic                        tick_r;
    logic                        done_r;
    logic                        active_r;
    logic [W-1:0]                cur_inc_r;
    logic [W-1:0]                cur_incinc_r;
    logic                        cur_dir_r;

    logic                        move_ready_s;
    logic                        push_s;
    logic                        pop_s;
    logic [W-1:0]                head_dur_s;
    logic [W-1:0]                head_inc_s;
    logic [W-1:0]                head_incinc_s;
    logic                        head_dir_s;
    logic [DIV_W-1:0]            d_eff_s;
    logic [DIV_W-1:0]            div_first_s;

    // Handshake, FIFO head and effective divisor decode.
    always_comb begin
        move_ready_s  = (count_r < CNT_FULL) && !abort;
        push_s        = move_valid && move_ready_s;
        pop_s         = (state_r == ST_LOAD) && (count_r != CNT_ZERO) && !abort;
        head_dur_s    = dur_mem_r[rd_ptr_r];
        head_inc_s    = inc_mem_r[rd_ptr_r];
        head_incinc_s = incinc_mem_r[rd_ptr_r];
        head_dir_s    = dir_mem_r[rd_ptr_r];
        if (clock_divisor < DIV_TWO) begin
            d_eff_s = DIV_TWO;
        end else begin
            d_eff_s = clock_divisor;
        end
        // A chained move already spent one cycle in LOAD, so keep the cadence unbroken.
        if (chain_r) begin
            div_first_s = d_eff_s - DIV_ONE;
        end else begin
            div_first_s = d_eff_s;
        end
    end

    // Move FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                dur_mem_r[i]    <= VAL_ZERO;
                inc_mem_r[i]    <= VAL_ZERO;
                incinc_mem_r[i] <= VAL_ZERO;
                dir_mem_r[i]    <= 1'b0;
            end
        end else if (abort) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                dur_mem_r[wr_ptr_r]    <= move_duration;
                inc_mem_r[wr_ptr_r]    <= move_increment;
                incinc_mem_r[wr_ptr_r] <= move_incrementincrement;
                dir_mem_r[wr_ptr_r]    <= move_dir;
                wr_ptr_r               <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer FSM: load, divided tick generation and per-move downcount.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            rem_r        <= VAL_ZERO;
            div_r        <= DIV_ZERO;
            d_r          <= DIV_ZERO;
            chain_r      <= 1'b0;
            load_r       <= 1'b0;
            tick_r       <= 1'b0;
            done_r       <= 1'b0;
            active_r     <= 1'b0;
            cur_inc_r    <= VAL_ZERO;
            cur_incinc_r <= VAL_ZERO;
            cur_dir_r    <= 1'b0;
        end else if (abort) begin
            state_r  <= ST_IDLE;
            rem_r    <= VAL_ZERO;
            div_r    <= DIV_ZERO;
            chain_r  <= 1'b0;
            load_r   <= 1'b0;
            tick_r   <= 1'b0;
            done_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            load_r <= 1'b0;
            tick_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    active_r <= 1'b0;
                    chain_r  <= 1'b0;
                    if (count_r != CNT_ZERO) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (!pop_s) begin
                        active_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (head_dur_s == VAL_ZERO) begin
                        // Zero-length moves are discarded silently.
                        active_r <= 1'b0;
                        if ((count_r > CNT_ONE) || push_s) begin
                            state_r <= ST_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cur_inc_r    <= head_inc_s;
                        cur_incinc_r <= head_incinc_s;
                        cur_dir_r    <= head_dir_s;
                        rem_r        <= head_dur_s;
                        d_r          <= d_eff_s;
                        div_r        <= div_first_s;
                        load_r       <= 1'b1;
                        active_r     <= 1'b1;
                        state_r      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (div_r == DIV_ONE) begin
                        tick_r <= 1'b1;
                        div_r  <= d_r;
                        rem_r  <= rem_r - VAL_ONE;
                        if (rem_r == VAL_ONE) begin
                            done_r  <= 1'b1;
                            chain_r <= 1'b1;
                            if ((count_r != CNT_ZERO) || push_s) begin
                                state_r <= ST_LOAD;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        div_r <= div_r - DIV_ONE;
                    end
                end
                default: begin
                    active_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_ready             = move_ready_s;
    assign load                   = load_r;
    assign tick                   = tick_r;
    assign move_done              = done_r;
    assign active                 = active_r;
    assign cur_increment          = cur_inc_r;
    assign cur_incrementincrement = cur_incinc_r;
    assign cur_dir                = cur_dir_r;
    assign queue_count            = count_r;

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Buffers coordinated-move descriptors from the SPI message handler and sequences them, one at a time, into the stepper step-timing datapath. Owns the move FIFO, the clock-divisor tick prescaler and the per-move tick downcount. Emits a one-cycle `load` strobe with the current move's parameters, then one `tick` strobe per divided clock period until the move's duration is exhausted. Sits between the SPI word state machine and the substep accumulator / `DualHBridge` step generator.

## Interface
- `MOVE_BUFFER_BITS`, 2: FIFO depth is 2^MOVE_BUFFER_BITS entries.
- `W`, 64: width of duration, increment and incrementincrement.
- `DIV_W`, 24: clock divisor width.

- `CLK` in 1: system clock (16 MHz); the only clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `move_valid` in 1: a descriptor is presented on `move_*`.
- `move_ready` out 1: the FIFO can accept; equals `queue_count < 2^MOVE_BUFFER_BITS` and `!abort`.
- `move_duration` in W: tick count of the move, unsigned.
- `move_increment` in W: initial increment, signed.
- `move_incrementincrement` in W: per-tick increment delta, signed.
- `move_dir` in 1: direction bit.
- `clock_divisor` in DIV_W: CLK cycles per tick; 0 and 1 are treated as 2.
- `abort` in 1: synchronous flush and stop.
- `load` out 1: one-cycle strobe; `cur_*` hold a new move from this cycle on.
- `tick` out 1: one-cycle strobe per divided period while a move is active.
- `move_done` out 1: one-cycle strobe, coincident with the final `tick` of a move.
- `cur_increment`, `cur_incrementincrement` out W; `cur_dir` out 1: parameters of the active move, registered.
- `active` out 1: a move is being executed.
- `queue_count` out MOVE_BUFFER_BITS+1: number of FIFO entries.

## Operation
- **Reset values:** every output except `move_ready` is 0; `move_ready` is 1. The FIFO, pointers, divider and downcount are all cleared. Asserting reset mid-move drops the move with no further strobes.
- **Write:** the FIFO pushes on `move_valid && move_ready`. A write attempted when full is ignored and must not corrupt the FIFO. Pointers wrap modulo the depth.
- **States:**
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD pops the head, latches `cur_*`, `remaining = duration` and the effective divisor D, then goes to RUN.
  - RUN: at each tick, decrement `remaining`. On the tick where `remaining` reaches 0, assert `move_done`. Go to LOAD if the FIFO is non-empty (evaluated on that same edge, including a same-cycle push into an empty FIFO), else go to IDLE.
- **Zero-duration move:** popped in LOAD with no `load`, `tick` or `move_done`, and discarded. The sequencer then proceeds to the next entry or to IDLE.
- **`load`:** asserted in the cycle after the pop edge, i.e. the first RUN cycle. `active` is high from that cycle through the `move_done` cycle. Between back-to-back moves `active` stays high.
- **Divisor:** sampled only at LOAD. Changes to `clock_divisor` mid-move have no effect until the next load.
- **Simultaneous push and pop:** `queue_count` is unchanged, and the data is correct even when the FIFO is empty or full.
- **`abort`:** takes priority over everything.
  - The next edge empties the FIFO, clears `remaining`, `active` and the divider, and enters IDLE.
  - No `tick`, `load` or `move_done` is asserted in the cycle after `abort` is sampled.
  - A push in the abort cycle is dropped.
  - The `cur_*` outputs hold their last values.

## Timing
- **From IDLE:** `load` occurs 2 cycles after the push edge of a descriptor into an empty, idle FIFO (LOAD cycle, then `load`). The first `tick` comes D cycles after the `load` cycle, and subsequent ticks every D cycles.
- **Back-to-back:** the tick cadence is unbroken. The next move's `load` is the cycle after the previous `move_done`, and its first `tick` is exactly D_new cycles after the previous final tick.
- **`load` and `tick`:** never coincident, guaranteed by D ≥ 2.
- **Move length:** a move with duration N produces exactly N ticks. The final tick has `move_done` = 1.

## Test plan
- **Single move:** reset, D=4, push {duration=3, inc=5, incinc=-1, dir=1}. Required: `load` at push+2 with cur_increment=5, cur_dir=1; ticks at load+4, +8, +12; `move_done` with the third tick; `active` low the next cycle; queue_count returns to 0.
- **Back-to-back:** D=40, push durations 2, 1, 3 while idle. Required: 6 ticks spaced exactly 40 cycles apart; 3 `load` strobes each 1 cycle after the prior `move_done`; `active` continuously high.
- **Full FIFO:** with MOVE_BUFFER_BITS=2, hold a long move active and push 5 descriptors. Required: queue_count=4, `move_ready`=0, the 5th descriptor ignored, and the 4 queued moves executed in push order.
- **Zero-duration move and divisor clamp:** clock_divisor=0, push duration 0 then duration 2. Required: no strobes for the first move; the second move's ticks are spaced 2 cycles apart.
- **Abort:** abort mid-move with 2 moves queued. Required: no tick after abort, queue_count=0, `active`=0 next cycle; a subsequent push executes normally.
- **Async reset:** assert `resetn`=0 mid-move, off-edge. Required: outputs go to reset values immediately; no strobes after release until a new push.
